// File: rtl/change_dispenser_if.sv
// Payout-side coin interface between the vending core (master) and the change dispenser (slave).
interface change_dispenser_if;
   logic       start;
   logic [7:0] amount;
   logic       clear;
   logic [3:0] hopper_empty;
   logic       hopper_ack;
   logic       coin_req;
   logic [1:0] coin_type;
   logic       busy;
   logic       done;
   logic       fault;
   logic [7:0] remaining;
   logic [7:0] coins_paid;

   modport master (
      output start, amount, clear, hopper_empty, hopper_ack,
      input  coin_req, coin_type, busy, done, fault, remaining, coins_paid
   );

   modport slave (
      input  start, amount, clear, hopper_empty, hopper_ack,
      output coin_req, coin_type, busy, done, fault, remaining, coins_paid
   );
endinterface

// File: rtl/change_dispenser.sv
// Greedy coin payout engine: ejects change largest-denomination-first through a hopper handshake.
module change_dispenser #(
   parameter int GAP_CYCLES  = 2,
   parameter int ACK_TIMEOUT = 255
) (
   input logic               clk,
   input logic               rst,
   change_dispenser_if.slave bus
);
   typedef enum logic [2:0] {IDLE, SELECT, REQ, GAP, DONE, FAULT} state_t;

   localparam logic [3:0] GAP_LOAD = 4'(GAP_CYCLES);
   localparam logic [7:0] ACK_LAST = 8'(ACK_TIMEOUT - 1);

   state_t     state;
   logic [1:0] coin_type;
   logic [7:0] remaining;
   logic [7:0] coins_paid;
   logic [3:0] gap_cnt;
   logic [7:0] ack_timer;
   logic [2:0] choice;

   // Returns {found, code}; strictly greedy, no backtracking over smaller coins.
   function automatic logic [2:0] pick(input logic [7:0] rem, input logic [3:0] empty);
      if (rem >= 8'd10 && !empty[3]) return 3'b111;
      if (rem >= 8'd5  && !empty[2]) return 3'b110;
      if (rem >= 8'd2  && !empty[1]) return 3'b101;
      if (rem >= 8'd1  && !empty[0]) return 3'b100;
      return 3'b000;
   endfunction

   function automatic logic [7:0] denom(input logic [1:0] code);
      case (code)
         2'b00:   return 8'd1;
         2'b01:   return 8'd2;
         2'b10:   return 8'd5;
         default: return 8'd10;
      endcase
   endfunction

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   assign choice = pick(remaining, bus.hopper_empty);

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         coin_type  <= 2'b00;
         remaining  <= 8'd0;
         coins_paid <= 8'd0;
         gap_cnt    <= 4'd0;
         ack_timer  <= 8'd0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  if (bus.amount != 8'd0) begin
                     remaining  <= bus.amount;
                     coins_paid <= 8'd0;
                     state      <= SELECT;
                  end else begin
                     state <= DONE;
                  end
               end
            end
            SELECT: begin
               if (remaining == 8'd0) begin
                  state <= DONE;
               end else if (choice[2]) begin
                  coin_type <= choice[1:0];
                  ack_timer <= 8'd0;
                  state     <= REQ;
               end else begin
                  state <= FAULT;
               end
            end
            REQ: begin
               // An ack on the final timeout cycle still counts as a paid coin.
               if (bus.hopper_ack) begin
                  remaining  <= remaining - denom(coin_type);
                  coins_paid <= sat_inc(coins_paid);
                  gap_cnt    <= GAP_LOAD;
                  state      <= GAP;
               end else if (ack_timer == ACK_LAST) begin
                  state <= FAULT;
               end else begin
                  ack_timer <= ack_timer + 8'd1;
               end
            end
            GAP: begin
               if (gap_cnt <= 4'd1) state <= SELECT;
               else                 gap_cnt <= gap_cnt - 4'd1;
            end
            DONE: state <= IDLE;
            FAULT: begin
               if (bus.clear) begin
                  remaining <= 8'd0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.coin_req   = (state == REQ);
   assign bus.coin_type  = coin_type;
   assign bus.busy       = (state == SELECT) || (state == REQ) || (state == GAP) || (state == FAULT);
   assign bus.done       = (state == DONE);
   assign bus.fault      = (state == FAULT);
   assign bus.remaining  = remaining;
   assign bus.coins_paid = coins_paid;
endmodule
